// File: rtl/fib_fifo_if.sv
// Handshake bundle between the control/start logic, the Fibonacci
// sequencer and the downstream word FIFO write port.
interface fib_fifo_if #(
    parameter int B   = 8,
    parameter int N_W = 5
);
    logic           start;
    logic [N_W-1:0] n;
    logic           fifo_full;
    logic           fifo_wr;
    logic [B-1:0]   fifo_w_data;
    logic           busy;
    logic           done;
    logic           ovf;

    // Control/FIFO side: requests runs and reports FIFO fullness.
    modport master (
        output start, n, fifo_full,
        input  fifo_wr, fifo_w_data, busy, done, ovf
    );

    // Sequencer side: pushes terms into the FIFO.
    modport slave (
        input  start, n, fifo_full,
        output fifo_wr, fifo_w_data, busy, done, ovf
    );
endinterface

// File: rtl/fib_fifo_seq.sv
// Fibonacci sequencer: pushes F(0)..F(n-1), B-bit truncated, into a word
// FIFO one term per accepted cycle, stalling while the FIFO is full.
// Tracks true overflow of pushed terms and pulses done at end of run.
module fib_fifo_seq #(
    parameter int B   = 8,
    parameter int N_W = 5
) (
    input  logic       clk,
    input  logic       reset,
    fib_fifo_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [B-1:0]   a;
    logic [B-1:0]   b;
    logic [N_W-1:0] cnt;
    logic           ova;
    logic           ovb;
    logic           ovf;
    logic           busy_q;
    logic           done_q;
    logic [B:0]     sum;
    logic           accept;

    // Next term with its carry-out; the carry only feeds the overflow tracking.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
    end

    // Write only in RUN and never into a full FIFO; reset drops it at once.
    always_comb begin
        accept = (state == RUN) && !bus.fifo_full;
    end

    // Sequencer FSM with its datapath and registered status outputs.
    // ova/ovb mark whether a/b exceed B bits in true value, so ovf is set
    // only when an overflowed term is actually pushed, not when computed ahead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a      <= '0;
            b      <= B'(1);
            cnt    <= '0;
            ova    <= 1'b0;
            ovb    <= 1'b0;
            ovf    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ovf    <= 1'b0;
                        busy_q <= 1'b1;
                        if (bus.n != '0) begin
                            state <= RUN;
                            cnt   <= bus.n;
                            a     <= '0;
                            b     <= B'(1);
                            ova   <= 1'b0;
                            ovb   <= 1'b0;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        a   <= b;
                        b   <= sum[B-1:0];
                        ova <= ovb;
                        ovb <= ova | ovb | sum[B];
                        ovf <= ovf | ova;
                        cnt <= cnt - N_W'(1);
                        if (cnt == N_W'(1)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fifo_wr     = accept;
    assign bus.fifo_w_data = a;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.ovf         = ovf;

endmodule

// File: tb/tb_fib_fifo_seq.sv
// Directed bench for fib_fifo_seq: normal runs, backpressure, n=0,
// overflow boundary, mid-run reset and start-while-busy.
module tb_fib_fifo_seq;

    localparam int B   = 8;
    localparam int N_W = 5;

    logic clk = 1'b0;
    logic reset;

    fib_fifo_if #(.B(B), .N_W(N_W)) bus ();

    fib_fifo_seq #(.B(B), .N_W(N_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Hand-computed Fibonacci terms truncated to 8 bits (377->121, 610->98).
    logic [7:0] fib_tab [0:15] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                                   8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121, 8'd98};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int cnt);
        bus.start = 1'b1;
        bus.n     = N_W'(cnt);
        tick();
        bus.start = 1'b0;
    endtask

    // Expect consecutive accepted writes of terms first..last, one per cycle.
    task automatic pushes(input string tag, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            #1;
            chk({tag, "_wr"},   32'(bus.fifo_wr),     32'd1);
            chk({tag, "_data"}, 32'(bus.fifo_w_data), 32'(fib_tab[i]));
            chk({tag, "_busy"}, 32'(bus.busy),        32'd1);
            chk({tag, "_done"}, 32'(bus.done),        32'd0);
            tick();
        end
    endtask

    // Expect the single done cycle, then idle.
    task automatic finish_run(input string tag);
        #1;
        chk({tag, "_done_hi"}, 32'(bus.done),    32'd1);
        chk({tag, "_busy_d"},  32'(bus.busy),    32'd1);
        chk({tag, "_wr_d"},    32'(bus.fifo_wr), 32'd0);
        tick();
        #1;
        chk({tag, "_done_lo"}, 32'(bus.done),    32'd0);
        chk({tag, "_busy_lo"}, 32'(bus.busy),    32'd0);
        chk({tag, "_wr_idle"}, 32'(bus.fifo_wr), 32'd0);
        tick();
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.n         = '0;
        bus.fifo_full = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_wr",   32'(bus.fifo_wr),     32'd0);
        chk("rst_data", 32'(bus.fifo_w_data), 32'd0);
        chk("rst_busy", 32'(bus.busy),        32'd0);
        chk("rst_done", 32'(bus.done),        32'd0);
        chk("rst_ovf",  32'(bus.ovf),         32'd0);
        reset = 1'b0;
        tick();
        chk("idle_wr", 32'(bus.fifo_wr), 32'd0);

        // 1: n=5, no backpressure
        start_run(5);
        pushes("t1", 0, 4);
        finish_run("t1");
        chk("t1_ovf", 32'(bus.ovf), 32'd0);

        // 2: n=8, FIFO full for 3 cycles after the 3rd write
        start_run(8);
        pushes("t2a", 0, 2);
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_stall_wr",   32'(bus.fifo_wr),     32'd0);
            chk("t2_stall_data", 32'(bus.fifo_w_data), 32'd2);
            chk("t2_stall_busy", 32'(bus.busy),        32'd1);
            tick();
        end
        bus.fifo_full = 1'b0;
        pushes("t2b", 3, 7);
        finish_run("t2");

        // 3: n=0, done in the cycle after start, no writes
        start_run(0);
        finish_run("t3");

        // 4: overflow boundary; n=14 stays in range, n=15 pushes 377
        start_run(14);
        pushes("t4a", 0, 13);
        finish_run("t4a");
        chk("t4a_ovf", 32'(bus.ovf), 32'd0);

        start_run(15);
        pushes("t4b", 0, 13);
        #1;
        chk("t4b_last_data", 32'(bus.fifo_w_data), 32'd121);
        chk("t4b_ovf_pre",   32'(bus.ovf),         32'd0);
        tick();
        #1;
        chk("t4b_ovf_done", 32'(bus.ovf),  32'd1);
        chk("t4b_done",     32'(bus.done), 32'd1);
        tick();
        tick();
        chk("t4b_ovf_sticky", 32'(bus.ovf), 32'd1);
        start_run(1);
        #1;
        chk("t4c_ovf_clr", 32'(bus.ovf), 32'd0);
        tick();
        finish_run("t4c");

        // 5: reset after 2nd write of an n=10 run
        start_run(10);
        pushes("t5a", 0, 1);
        reset = 1'b1;
        #1;
        chk("t5_rst_wr",   32'(bus.fifo_wr),     32'd0);
        chk("t5_rst_busy", 32'(bus.busy),        32'd0);
        chk("t5_rst_done", 32'(bus.done),        32'd0);
        chk("t5_rst_data", 32'(bus.fifo_w_data), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("t5_post_done", 32'(bus.done), 32'd0);
        chk("t5_post_busy", 32'(bus.busy), 32'd0);
        start_run(3);
        pushes("t5b", 0, 2);
        finish_run("t5b");

        // 6: start n=2 pulsed during an n=6 run is ignored
        start_run(6);
        pushes("t6a", 0, 1);
        bus.start = 1'b1;
        bus.n     = N_W'(2);
        pushes("t6b", 2, 2);
        bus.start = 1'b0;
        pushes("t6c", 3, 5);
        finish_run("t6");
        #1;
        chk("t6_quiet_wr",   32'(bus.fifo_wr), 32'd0);
        chk("t6_quiet_done", 32'(bus.done),    32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
